// File: rtl/matrix_pkg.sv
// Shared matrix ALU definitions: op codes, operand/result widths, per-requester operand bundle.
// Pure types and constants; no logic, so no latency or backpressure of its own.
package matrix_pkg;

    localparam int MAT_W = 200;
    localparam int RES_W = 400;
    localparam int DIM_W = 3;
    localparam int OP_W  = 3;
    localparam int SCL_W = 8;

    localparam logic [OP_W-1:0] OP_TRANSPOSE = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD       = 3'd1;
    localparam logic [OP_W-1:0] OP_SCALAR    = 3'd2;
    localparam logic [OP_W-1:0] OP_MUL       = 3'd3;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [DIM_W-1:0] m_a;
        logic [DIM_W-1:0] n_a;
        logic [DIM_W-1:0] m_b;
        logic [DIM_W-1:0] n_b;
        logic [MAT_W-1:0] a;
        logic [MAT_W-1:0] b;
        logic [SCL_W-1:0] scalar;
    } operand_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_START,
        ST_WAIT,
        ST_RESPOND
    } arb_state_e;

    function automatic logic op_is_valid(input logic [OP_W-1:0] op);
        return op <= OP_MUL;
    endfunction

endpackage

// File: rtl/matrix_alu_arbiter_rr_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping. Purely combinational,
// zero latency; it only selects, holding off the losers is the caller's job.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    always_comb begin
        int idx;
        pick  = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!valid && req[idx]) begin
                valid     = 1'b1;
                pick[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_alu_arbiter.sv
// Round-robin share of one matrix ALU: alu_start 3 cycles after req from idle, done/err ALU latency + 4.
// Losers simply wait with req held; the owner keeps its slot until done/err even if it drops req.
module matrix_alu_arbiter
    import matrix_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [OP_W*NUM_REQ-1:0]    req_op,
    input  logic [DIM_W*NUM_REQ-1:0]   req_m_a,
    input  logic [DIM_W*NUM_REQ-1:0]   req_n_a,
    input  logic [DIM_W*NUM_REQ-1:0]   req_m_b,
    input  logic [DIM_W*NUM_REQ-1:0]   req_n_b,
    input  logic [MAT_W*NUM_REQ-1:0]   req_a,
    input  logic [MAT_W*NUM_REQ-1:0]   req_b,
    input  logic [SCL_W*NUM_REQ-1:0]   req_scalar,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         err,
    output logic [RES_W-1:0]           res_flat,
    output logic [DIM_W-1:0]           res_m,
    output logic [DIM_W-1:0]           res_n,
    output logic                       busy,
    output logic                       alu_start,
    output logic [OP_W-1:0]            alu_op,
    output logic [DIM_W-1:0]           alu_m_a,
    output logic [DIM_W-1:0]           alu_n_a,
    output logic [DIM_W-1:0]           alu_m_b,
    output logic [DIM_W-1:0]           alu_n_b,
    output logic [MAT_W-1:0]           alu_a,
    output logic [MAT_W-1:0]           alu_b,
    output logic [SCL_W-1:0]           alu_scalar,
    input  logic                       alu_done,
    input  logic [RES_W-1:0]           alu_result,
    input  logic [DIM_W-1:0]           alu_res_m,
    input  logic [DIM_W-1:0]           alu_res_n
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, rr_ptr_q, pick_idx;
    logic [NUM_REQ-1:0] pick;
    logic              pick_vld;
    logic              err_flag_q;
    logic [TMR_W-1:0]  timer_q;
    logic              alu_start_q;
    operand_t          alu_q;
    logic [RES_W-1:0]  res_q;
    logic [DIM_W-1:0]  res_m_q, res_n_q;
    operand_t          slot [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        assign slot[i] = '{op:     req_op[OP_W*i +: OP_W],
                           m_a:    req_m_a[DIM_W*i +: DIM_W],
                           n_a:    req_n_a[DIM_W*i +: DIM_W],
                           m_b:    req_m_b[DIM_W*i +: DIM_W],
                           n_b:    req_n_b[DIM_W*i +: DIM_W],
                           a:      req_a[MAT_W*i +: MAT_W],
                           b:      req_b[MAT_W*i +: MAT_W],
                           scalar: req_scalar[SCL_W*i +: SCL_W]};
    end

    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req   (req),
        .ptr   (rr_ptr_q),
        .pick  (pick),
        .valid (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (pick_vld) state_d = ST_GRANT;
            ST_GRANT:   state_d = op_is_valid(slot[owner_q].op) ? ST_START : ST_RESPOND;
            ST_START:   state_d = ST_WAIT;
            ST_WAIT:    if (alu_done || timer_q == TMR_LAST) state_d = ST_RESPOND;
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            err_flag_q  <= 1'b0;
            timer_q     <= '0;
            alu_start_q <= 1'b0;
            alu_q       <= '0;
            res_q       <= '0;
            res_m_q     <= '0;
            res_n_q     <= '0;
        end else begin
            // Registered so the ALU sees start in the first WAIT cycle, alongside timer 0.
            alu_start_q <= (state_q == ST_START);
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) owner_q <= pick_idx;
                end
                ST_GRANT: begin
                    alu_q <= slot[owner_q];
                    if (!op_is_valid(slot[owner_q].op)) err_flag_q <= 1'b1;
                end
                ST_START: begin
                    timer_q <= '0;
                end
                ST_WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    if (alu_done) begin
                        res_q   <= alu_result;
                        res_m_q <= alu_res_m;
                        res_n_q <= alu_res_n;
                    end else if (timer_q == TMR_LAST) begin
                        err_flag_q <= 1'b1;
                    end
                end
                ST_RESPOND: begin
                    rr_ptr_q   <= (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
                    err_flag_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        grant = '0;
        done  = '0;
        err   = '0;
        if (state_q != ST_IDLE) grant[owner_q] = 1'b1;
        if (state_q == ST_RESPOND) begin
            if (err_flag_q) err[owner_q]  = 1'b1;
            else            done[owner_q] = 1'b1;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign alu_start  = alu_start_q;
    assign alu_op     = alu_q.op;
    assign alu_m_a    = alu_q.m_a;
    assign alu_n_a    = alu_q.n_a;
    assign alu_m_b    = alu_q.m_b;
    assign alu_n_b    = alu_q.n_b;
    assign alu_a      = alu_q.a;
    assign alu_b      = alu_q.b;
    assign alu_scalar = alu_q.scalar;
    assign res_flat   = res_q;
    assign res_m      = res_m_q;
    assign res_n      = res_n_q;

endmodule
